execute_stage: RTL and testbench

EXECUTE_STAGE -- requirements
Module: execute_stage

---
 rtl/execute_stage.sv | 158 +++++++++++++++
 tb/tb_execute_stage.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - ALU execute stage with a multi-cycle shift-add multiplier
module execute_stage #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             valid_id,
   input  logic [2:0]       op_id,
   input  logic [WIDTH-1:0] a_id,
   input  logic [WIDTH-1:0] b_id,
   input  logic [WIDTH-1:0] DM_data_id,
   input  logic             mem_rw_id,
   input  logic             mem_en_id,
   input  logic             mem_mux_sel_id,
   output logic [WIDTH-1:0] ans_ex,
   output logic [WIDTH-1:0] DM_data_ex,
   output logic             mem_rw_ex,
   output logic             mem_en_ex,
   output logic             mem_mux_sel_ex,
   output logic             valid_ex,
   output logic             zero_ex,
   output logic             stall
);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_SLL = 3'b101;
   localparam logic [2:0] OP_SRL = 3'b110;
   localparam logic [2:0] OP_MUL = 3'b111;

   typedef enum logic {IDLE, MUL_BUSY} state_t;

   state_t           state;
   logic [3:0]       cnt;
   logic [WIDTH-1:0] mul_a;
   logic [WIDTH-1:0] mul_b;
   logic [WIDTH-1:0] mul_acc;
   logic [WIDTH-1:0] mul_dm;
   logic             mul_rw;
   logic             mul_en;
   logic             mul_sel;
   logic [WIDTH-1:0] alu_res;
   logic [WIDTH-1:0] acc_next;

   // Single-cycle ALU result; MUL is handled by the iterative datapath instead
   always_comb begin
      alu_res = '0;
      case (op_id)
         OP_ADD:  alu_res = a_id + b_id;
         OP_SUB:  alu_res = a_id - b_id;
         OP_AND:  alu_res = a_id & b_id;
         OP_OR:   alu_res = a_id | b_id;
         OP_XOR:  alu_res = a_id ^ b_id;
         OP_SLL:  alu_res = a_id << b_id[3:0];
         OP_SRL:  alu_res = a_id >> b_id[3:0];
         OP_MUL:  alu_res = '0;
         default: alu_res = '0;
      endcase
   end

   // One shift-add step: accumulate the shifted multiplicand when the multiplier LSB is set
   always_comb begin
      acc_next = mul_acc + (mul_b[0] ? mul_a : '0);
   end

   // Hold upstream during the MUL accept cycle and every busy cycle except the last
   always_comb begin
      stall = 1'b0;
      if (reset) begin
         if (state == IDLE)
            stall = valid_id && (op_id == OP_MUL);
         else
            stall = (cnt != 4'd15);
      end
   end

   // Stage registers and the IDLE/MUL_BUSY controller
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state          <= IDLE;
         cnt            <= '0;
         mul_a          <= '0;
         mul_b          <= '0;
         mul_acc        <= '0;
         mul_dm         <= '0;
         mul_rw         <= 1'b0;
         mul_en         <= 1'b0;
         mul_sel        <= 1'b0;
         ans_ex         <= '0;
         DM_data_ex     <= '0;
         mem_rw_ex      <= 1'b0;
         mem_en_ex      <= 1'b0;
         mem_mux_sel_ex <= 1'b0;
         valid_ex       <= 1'b0;
         zero_ex        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               cnt <= '0;
               if (valid_id && (op_id == OP_MUL)) begin
                  mul_a     <= a_id;
                  mul_b     <= b_id;
                  mul_acc   <= '0;
                  mul_dm    <= DM_data_id;
                  mul_rw    <= mem_rw_id;
                  mul_en    <= mem_en_id;
                  mul_sel   <= mem_mux_sel_id;
                  state     <= MUL_BUSY;
                  valid_ex  <= 1'b0;
                  mem_en_ex <= 1'b0;
                  mem_rw_ex <= 1'b0;
               end else if (valid_id) begin
                  ans_ex         <= alu_res;
                  zero_ex        <= (alu_res == '0);
                  DM_data_ex     <= DM_data_id;
                  mem_rw_ex      <= mem_rw_id;
                  mem_en_ex      <= mem_en_id;
                  mem_mux_sel_ex <= mem_mux_sel_id;
                  valid_ex       <= 1'b1;
               end else begin
                  valid_ex  <= 1'b0;
                  mem_en_ex <= 1'b0;
                  mem_rw_ex <= 1'b0;
               end
            end
            MUL_BUSY: begin
               mul_acc <= acc_next;
               mul_a   <= mul_a << 1;
               mul_b   <= mul_b >> 1;
               cnt     <= cnt + 4'd1;
               if (cnt == 4'd15) begin
                  ans_ex         <= acc_next;
                  zero_ex        <= (acc_next == '0);
                  DM_data_ex     <= mul_dm;
                  mem_rw_ex      <= mul_rw;
                  mem_en_ex      <= mul_en;
                  mem_mux_sel_ex <= mul_sel;
                  valid_ex       <= 1'b1;
                  state          <= IDLE;
                  cnt            <= '0;
               end else begin
                  valid_ex  <= 1'b0;
                  mem_en_ex <= 1'b0;
                  mem_rw_ex <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_execute_stage.sv
// tb/tb_execute_stage.sv - directed self-checking bench for execute_stage
module tb_execute_stage;

   localparam int WIDTH = 16;

   logic             clk;
   logic             reset;
   logic             valid_id;
   logic [2:0]       op_id;
   logic [WIDTH-1:0] a_id;
   logic [WIDTH-1:0] b_id;
   logic [WIDTH-1:0] DM_data_id;
   logic             mem_rw_id;
   logic             mem_en_id;
   logic             mem_mux_sel_id;
   logic [WIDTH-1:0] ans_ex;
   logic [WIDTH-1:0] DM_data_ex;
   logic             mem_rw_ex;
   logic             mem_en_ex;
   logic             mem_mux_sel_ex;
   logic             valid_ex;
   logic             zero_ex;
   logic             stall;

   int pass_cnt = 0;
   int total_cnt = 0;

   execute_stage #(.WIDTH(WIDTH)) dut (
      .clk            (clk),
      .reset          (reset),
      .valid_id       (valid_id),
      .op_id          (op_id),
      .a_id           (a_id),
      .b_id           (b_id),
      .DM_data_id     (DM_data_id),
      .mem_rw_id      (mem_rw_id),
      .mem_en_id      (mem_en_id),
      .mem_mux_sel_id (mem_mux_sel_id),
      .ans_ex         (ans_ex),
      .DM_data_ex     (DM_data_ex),
      .mem_rw_ex      (mem_rw_ex),
      .mem_en_ex      (mem_en_ex),
      .mem_mux_sel_ex (mem_mux_sel_ex),
      .valid_ex       (valid_ex),
      .zero_ex        (zero_ex),
      .stall          (stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive(input logic v, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] dm, input logic rw, input logic en, input logic sel);
      valid_id       = v;
      op_id          = op;
      a_id           = a;
      b_id           = b;
      DM_data_id     = dm;
      mem_rw_id      = rw;
      mem_en_id      = en;
      mem_mux_sel_id = sel;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Run a MUL that is already presented; hold it while stall is high, then present the follow-up
   task automatic run_mul(input logic nv, input logic [2:0] nop, input logic [15:0] na, input logic [15:0] nb,
                          output int edges, output int stalls, output int bad_bubbles);
      logic s;
      edges = 0;
      stalls = 0;
      bad_bubbles = 0;
      while (edges < 40) begin
         #1;
         s = stall;
         if (s) stalls++;
         if (edges > 0 && (valid_ex !== 1'b0 || mem_en_ex !== 1'b0 || mem_rw_ex !== 1'b0)) bad_bubbles++;
         tick();
         edges++;
         if (!s) drive(nv, nop, na, nb, 16'h0, 1'b0, 1'b0, 1'b0);
         if (valid_ex === 1'b1) break;
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      drive(1'b1, 3'b111, 16'h1234, 16'h5678, 16'h9ABC, 1'b1, 1'b1, 1'b1);
      tick();
      tick();
      total_cnt++;
      if ({ans_ex, DM_data_ex, mem_rw_ex, mem_en_ex, mem_mux_sel_ex, valid_ex, zero_ex} !== '0)
         $display("FAIL reset_outputs: got ans=%h dm=%h v=%b expected all 0", ans_ex, DM_data_ex, valid_ex);
      else pass_cnt++;
      total_cnt++;
      if (stall !== 1'b0) $display("FAIL reset_stall: got %b expected 0", stall);
      else pass_cnt++;
      drive(1'b0, 3'b000, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      tick();
      // ADD in flight, then reset asserted between edges
      drive(1'b1, 3'b000, 16'h0007, 16'h0008, 16'h1111, 1'b1, 1'b1, 1'b1);
      tick();
      total_cnt++;
      if (ans_ex !== 16'h000F || valid_ex !== 1'b1) $display("FAIL pre_reset_add: got ans=%h v=%b expected 000f 1", ans_ex, valid_ex);
      else pass_cnt++;
      drive(1'b1, 3'b111, 16'h0002, 16'h0003, 16'h0, 1'b0, 1'b0, 1'b0);
      #3;
      reset = 1'b0;
      #1;
      total_cnt++;
      if ({ans_ex, DM_data_ex, mem_rw_ex, mem_en_ex, mem_mux_sel_ex, valid_ex, zero_ex} !== '0 || stall !== 1'b0)
         $display("FAIL async_reset: got ans=%h dm=%h v=%b stall=%b expected all 0", ans_ex, DM_data_ex, valid_ex, stall);
      else pass_cnt++;
      @(negedge clk);
      reset = 1'b1;
      drive(1'b1, 3'b000, 16'h0002, 16'h0003, 16'h0, 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b0, 3'b000, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
      total_cnt++;
      if (ans_ex !== 16'h0005 || valid_ex !== 1'b1) $display("FAIL post_reset_add: got ans=%h v=%b expected 0005 1", ans_ex, valid_ex);
      else pass_cnt++;
   endtask

   task automatic test_alu();
      drive(1'b1, 3'b000, 16'hFFFF, 16'h0001, 16'h0, 1'b0, 1'b0, 1'b0);
      tick();
      total_cnt++;
      if (ans_ex !== 16'h0000 || zero_ex !== 1'b1 || valid_ex !== 1'b1)
         $display("FAIL add_wrap: got ans=%h z=%b v=%b expected 0000 1 1", ans_ex, zero_ex, valid_ex);
      else pass_cnt++;
      drive(1'b1, 3'b001, 16'h0003, 16'h0005, 16'h0, 1'b0, 1'b0, 1'b0);
      tick();
      total_cnt++;
      if (ans_ex !== 16'hFFFE || zero_ex !== 1'b0) $display("FAIL sub_borrow: got ans=%h z=%b expected fffe 0", ans_ex, zero_ex);
      else pass_cnt++;
      drive(1'b1, 3'b101, 16'h0001, 16'h0013, 16'h0, 1'b0, 1'b0, 1'b0);
      tick();
      total_cnt++;
      if (ans_ex !== 16'h0008) $display("FAIL sll: got %h expected 0008", ans_ex);
      else pass_cnt++;
      drive(1'b1, 3'b110, 16'h8000, 16'h000F, 16'h0, 1'b0, 1'b0, 1'b0);
      tick();
      total_cnt++;
      if (ans_ex !== 16'h0001) $display("FAIL srl: got %h expected 0001", ans_ex);
      else pass_cnt++;
      drive(1'b1, 3'b010, 16'hF0F0, 16'h3C3C, 16'h0, 1'b0, 1'b0, 1'b0);
      tick();
      total_cnt++;
      if (ans_ex !== 16'h3030) $display("FAIL and: got %h expected 3030", ans_ex);
      else pass_cnt++;
      drive(1'b1, 3'b011, 16'hF0F0, 16'h3C3C, 16'h0, 1'b0, 1'b0, 1'b0);
      tick();
      total_cnt++;
      if (ans_ex !== 16'hFCFC) $display("FAIL or: got %h expected fcfc", ans_ex);
      else pass_cnt++;
      drive(1'b1, 3'b100, 16'hF0F0, 16'h3C3C, 16'h0, 1'b0, 1'b0, 1'b0);
      tick();
      total_cnt++;
      if (ans_ex !== 16'hCCCC) $display("FAIL xor: got %h expected cccc", ans_ex);
      else pass_cnt++;
   endtask

   task automatic test_bubble();
      drive(1'b1, 3'b000, 16'h0100, 16'h0023, 16'hABCD, 1'b1, 1'b1, 1'b1);
      tick();
      total_cnt++;
      if (ans_ex !== 16'h0123 || DM_data_ex !== 16'hABCD || {mem_rw_ex, mem_en_ex, mem_mux_sel_ex} !== 3'b111)
         $display("FAIL store_ctrl: got ans=%h dm=%h ctl=%b%b%b expected 0123 abcd 111",
                  ans_ex, DM_data_ex, mem_rw_ex, mem_en_ex, mem_mux_sel_ex);
      else pass_cnt++;
      drive(1'b0, 3'b000, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
      tick();
      total_cnt++;
      if (valid_ex !== 1'b0 || mem_en_ex !== 1'b0 || mem_rw_ex !== 1'b0 || ans_ex !== 16'h0123 ||
          DM_data_ex !== 16'hABCD || mem_mux_sel_ex !== 1'b1 || zero_ex !== 1'b0)
         $display("FAIL bubble_hold: got v=%b en=%b rw=%b ans=%h dm=%h sel=%b expected 0 0 0 0123 abcd 1",
                  valid_ex, mem_en_ex, mem_rw_ex, ans_ex, DM_data_ex, mem_mux_sel_ex);
      else pass_cnt++;
   endtask

   task automatic test_mul();
      int edges, stalls, bad;
      drive(1'b1, 3'b111, 16'h0123, 16'h0010, 16'h5555, 1'b1, 1'b1, 1'b1);
      run_mul(1'b0, 3'b000, 16'h0, 16'h0, edges, stalls, bad);
      total_cnt++;
      if (stalls !== 16) $display("FAIL mul_stall_cycles: got %0d expected 16", stalls);
      else pass_cnt++;
      total_cnt++;
      if (edges !== 17) $display("FAIL mul_latency: got %0d edges expected 17", edges);
      else pass_cnt++;
      total_cnt++;
      if (bad !== 0) $display("FAIL mul_bubbles: got %0d non-bubble busy cycles expected 0", bad);
      else pass_cnt++;
      total_cnt++;
      if (ans_ex !== 16'h1230 || valid_ex !== 1'b1 || mem_en_ex !== 1'b1 || mem_rw_ex !== 1'b1 ||
          DM_data_ex !== 16'h5555 || mem_mux_sel_ex !== 1'b1)
         $display("FAIL mul_result: got ans=%h v=%b en=%b rw=%b dm=%h expected 1230 1 1 1 5555",
                  ans_ex, valid_ex, mem_en_ex, mem_rw_ex, DM_data_ex);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (valid_ex !== 1'b0 || stall !== 1'b0) $display("FAIL mul_no_reaccept: got v=%b stall=%b expected 0 0", valid_ex, stall);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      int edges, stalls, bad;
      drive(1'b1, 3'b111, 16'hFFFF, 16'hFFFF, 16'h0, 1'b0, 1'b0, 1'b0);
      run_mul(1'b1, 3'b000, 16'h0010, 16'h0020, edges, stalls, bad);
      total_cnt++;
      if (ans_ex !== 16'h0001 || zero_ex !== 1'b0 || edges !== 17)
         $display("FAIL mul_ffff: got ans=%h z=%b edges=%0d expected 0001 0 17", ans_ex, zero_ex, edges);
      else pass_cnt++;
      tick();
      drive(1'b0, 3'b000, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
      total_cnt++;
      if (ans_ex !== 16'h0030 || valid_ex !== 1'b1) $display("FAIL b2b_add: got ans=%h v=%b expected 0030 1", ans_ex, valid_ex);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid_mul();
      int seen;
      drive(1'b1, 3'b111, 16'h0007, 16'h0009, 16'h0, 1'b1, 1'b1, 1'b0);
      tick();
      for (int i = 0; i < 8; i++) tick();
      #2;
      reset = 1'b0;
      #1;
      total_cnt++;
      if (stall !== 1'b0 || valid_ex !== 1'b0 || ans_ex !== 16'h0000)
         $display("FAIL mid_mul_reset: got stall=%b v=%b ans=%h expected 0 0 0000", stall, valid_ex, ans_ex);
      else pass_cnt++;
      drive(1'b0, 3'b000, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (valid_ex !== 1'b0 || stall !== 1'b0) seen++;
      end
      total_cnt++;
      if (seen !== 0) $display("FAIL mul_aborted: got %0d cycles with valid/stall expected 0", seen);
      else pass_cnt++;
      drive(1'b1, 3'b000, 16'h0001, 16'h0001, 16'h0, 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b0, 3'b000, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
      total_cnt++;
      if (ans_ex !== 16'h0002 || valid_ex !== 1'b1) $display("FAIL post_abort_add: got ans=%h v=%b expected 0002 1", ans_ex, valid_ex);
      else pass_cnt++;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

   initial begin
      drive(1'b0, 3'b000, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
      test_reset();
      test_alu();
      test_bubble();
      test_mul();
      test_back_to_back();
      test_reset_mid_mul();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
